dest_reg_pipe: RTL and testbench
================================

DEST_REG_PIPE -- requirements
Module: dest_reg_pipe

Interface
REQ-001 SHALL have parameter STAGES, default 3, meaning number of pipeline stages from destination entry to write-back (legal 1..4).
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register-address width; the decoded vector is 2**ADDR_W bits (32 by default).
REQ-003 SHALL have port Clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port Dest_In, input, ADDR_W, meaning the destination register selected upstream (rt or rd).
REQ-006 SHALL have port RegWrite_In, input, 1, meaning the entering instruction writes Dest_In.
REQ-007 SHALL have port Stall, input, 1, meaning hold every stage.
REQ-008 SHALL have port Flush, input, 1, meaning insert a bubble into stage 0.
REQ-009 SHALL have port Rs_Addr, input, ADDR_W, meaning the first hazard-query register.
REQ-010 SHALL have port Rt_Addr, input, ADDR_W, meaning the second hazard-query register.
REQ-011 SHALL have port WB_Dest, output, ADDR_W, meaning the final-stage destination.
REQ-012 SHALL have port WB_We, output, 1, meaning the final-stage write enable.
REQ-013 SHALL have port WB_OneHot, output, 2**ADDR_W, meaning the decoded register-file write strobe.
REQ-014 SHALL have port Busy, output, 2**ADDR_W, meaning the bitmap of registers with a pending write in any stage.
REQ-015 SHALL have ports Rs_Hit and Rt_Hit, output, 1 each, meaning the queried register has a pending write.

Function
REQ-016 Each stage SHALL hold {dest, we}; a bubble is {0, 0}.
REQ-017 On each edge with Stall=0, stage 0 SHALL load {Dest_In, RegWrite_In} (or a bubble if Flush=1), and stage i SHALL load stage i-1.
REQ-018 On an edge with Stall=1, stages 1..STAGES-1 SHALL hold; stage 0 SHALL hold if Flush=0 and SHALL become a bubble if Flush=1.
REQ-019 An entry loaded at edge k SHALL appear on WB_Dest/WB_We after edge k+STAGES-1, i.e. STAGES edges after its presentation with no stalls.
REQ-020 WB_Dest and WB_We SHALL be driven directly from final-stage registers.
REQ-021 WB_OneHot SHALL equal 1<<WB_Dest when WB_We=1 and all-zero otherwise.
REQ-022 Busy SHALL be the bitwise OR of the decoded one-hot of every stage, including the final stage.
REQ-023 Rs_Hit SHALL equal Busy[Rs_Addr], and Rt_Hit SHALL equal Busy[Rt_Addr], combinationally.
REQ-024 Multiple stages with the same dest SHALL set one Busy bit; clearing that bit requires all of those stages to drain.

Reset
REQ-025 Rst_n=0 SHALL immediately and asynchronously force every stage to a bubble, so WB_Dest=0, WB_We=0, WB_OneHot=0, Busy=0, Rs_Hit=0 and Rt_Hit=0.
REQ-026 A reset asserted mid-stream SHALL discard all in-flight entries with no write-back.
REQ-027 The first load after reset SHALL occur on the first rising edge with Rst_n=1.

Configuration
REQ-028 Macro DEST_PIPE_R0_SUPPRESS_EN, when defined, SHALL force we=0 on entry whenever Dest_In=0, so register 0 never appears in WB_We, WB_OneHot or Busy.
REQ-029 When DEST_PIPE_R0_SUPPRESS_EN is undefined, dest 0 SHALL pass through like any other register.

Structure
REQ-030 A shared package dest_pipe_pkg SHALL hold ADDR_W, NUM_REGS=32 and the stage-entry typedef {dest, we}.
REQ-031 Sub-module dest_decoder SHALL implement the ADDR_W-to-one-hot decode with enable; it is instantiated once per stage.

Verification
REQ-032 Reset, then Dest_In=9 with RegWrite_In=1 for one cycle (STAGES=3) -> WB_We=1, WB_Dest=9, WB_OneHot=0x00000200 exactly three edges later; Busy[9]=1 for those three cycles, then 0.
REQ-033 Stall=1 for 2 cycles while dest 7 is in stage 1 -> write-back is delayed by exactly 2 cycles, Busy[7] stays 1 throughout, and Rs_Addr=7 gives Rs_Hit=1.
REQ-034 Flush=1 on the entry edge of dest 12 -> WB_We is never 1 for dest 12 and Busy[12] stays 0; Flush with Stall=1 bubbles only stage 0.
REQ-035 Back-to-back dest 5, 5, 3 -> Busy[5] clears only after the second 5 writes back; WB_OneHot sequence is 0x20, 0x20, 0x08.
REQ-036 Dest_In=0 with RegWrite_In=1 -> with the macro, WB_We=0 and Busy=0; without it, WB_OneHot=0x00000001.
REQ-037 Assert Rst_n=0 between edges with three valid entries in flight -> all outputs are 0 before the next edge, and none of the entries writes back.

Source files
------------

// File: rtl/dest_pipe_pkg.sv
// Shared definitions for the destination-register pipeline: address width,
// register count and the per-stage {dest, we} entry format.
package dest_pipe_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic              we;
  } dest_entry_t;

endpackage

// File: rtl/dest_decoder.sv
// Binary-to-one-hot register decode with enable; all-zero when disabled.
module dest_decoder
  import dest_pipe_pkg::*;
#(
  parameter int unsigned SEL_W = ADDR_W
) (
  input  logic [SEL_W-1:0]      i_sel,
  input  logic                  i_en,
  output logic [(2**SEL_W)-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_sel] = 1'b1;
    end
  end

endmodule

// File: rtl/dest_reg_pipe.sv
// Destination-register pipeline with per-stage decode, pending-write bitmap
// and hazard queries. Optional macro DEST_PIPE_R0_SUPPRESS_EN drops writes to r0.
module dest_reg_pipe #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned ADDR_W = dest_pipe_pkg::ADDR_W
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [ADDR_W-1:0]      Dest_In,
  input  logic                   RegWrite_In,
  input  logic                   Stall,
  input  logic                   Flush,
  input  logic [ADDR_W-1:0]      Rs_Addr,
  input  logic [ADDR_W-1:0]      Rt_Addr,
  output logic [ADDR_W-1:0]      WB_Dest,
  output logic                   WB_We,
  output logic [(2**ADDR_W)-1:0] WB_OneHot,
  output logic [(2**ADDR_W)-1:0] Busy,
  output logic                   Rs_Hit,
  output logic                   Rt_Hit
);

  localparam int unsigned NREG = 2**ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic              we;
  } stage_t;

  stage_t          r_stage [STAGES];
  stage_t          w_entry;
  logic [NREG-1:0] w_dec   [STAGES];

  always_comb begin
    w_entry.dest = Dest_In;
`ifdef DEST_PIPE_R0_SUPPRESS_EN
    w_entry.we   = RegWrite_In && (Dest_In != '0);
`else
    w_entry.we   = RegWrite_In;
`endif
  end

  // Flush only ever affects stage 0, whether or not the pipe is stalled.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else if (!Stall) begin
      r_stage[0] <= Flush ? '0 : w_entry;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end else if (Flush) begin
      r_stage[0] <= '0;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_dec
    dest_decoder #(
      .SEL_W (ADDR_W)
    ) u_dec (
      .i_sel    (r_stage[s].dest),
      .i_en     (r_stage[s].we),
      .o_onehot (w_dec[s])
    );
  end

  always_comb begin
    Busy = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      Busy = Busy | w_dec[i];
    end
  end

  assign WB_Dest   = r_stage[STAGES-1].dest;
  assign WB_We     = r_stage[STAGES-1].we;
  assign WB_OneHot = w_dec[STAGES-1];
  assign Rs_Hit    = Busy[Rs_Addr];
  assign Rt_Hit    = Busy[Rt_Addr];

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Self-checking bench for dest_reg_pipe: directed scenarios plus random
// traffic against a queue-based model of in-flight destinations.
module tb_dest_reg_pipe;

  localparam int unsigned ST = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic [AW-1:0] Dest_In, Rs_Addr, Rt_Addr;
  logic          RegWrite_In, Stall, Flush;
  logic [AW-1:0] WB_Dest;
  logic          WB_We;
  logic [NR-1:0] WB_OneHot, Busy;
  logic          Rs_Hit, Rt_Hit;

  dest_reg_pipe #(
    .STAGES (ST),
    .ADDR_W (AW)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Dest_In     (Dest_In),
    .RegWrite_In (RegWrite_In),
    .Stall       (Stall),
    .Flush       (Flush),
    .Rs_Addr     (Rs_Addr),
    .Rt_Addr     (Rt_Addr),
    .WB_Dest     (WB_Dest),
    .WB_We       (WB_We),
    .WB_OneHot   (WB_OneHot),
    .Busy        (Busy),
    .Rs_Hit      (Rs_Hit),
    .Rt_Hit      (Rt_Hit)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned dest;
    bit          we;
  } ent_t;

  ent_t        pipe[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    pipe.delete();
    for (int i = 0; i < int'(ST); i++) pipe.push_back('{0, 1'b0});
  endtask

  // Index 0 is the youngest entry, the back of the queue is the one writing back.
  task automatic model_edge();
    ent_t e;
    if (!Rst_n) begin
      model_clear();
    end else if (!Stall) begin
      e.dest = Dest_In;
      e.we   = RegWrite_In;
`ifdef DEST_PIPE_R0_SUPPRESS_EN
      if (Dest_In == 0) e.we = 1'b0;
`endif
      if (Flush) e = '{0, 1'b0};
      pipe.push_front(e);
      void'(pipe.pop_back());
    end else if (Flush) begin
      pipe[0] = '{0, 1'b0};
    end
  endtask

  function automatic logic [63:0] m_busy();
    logic [63:0] b = '0;
    foreach (pipe[i]) if (pipe[i].we) b = b | (64'd1 << pipe[i].dest);
    return b;
  endfunction

  task automatic check_all();
    logic [63:0] b;
    ent_t        last;
    b    = m_busy();
    last = pipe[ST-1];
    chk("wb_dest",   64'(WB_Dest),   64'(last.dest));
    chk("wb_we",     64'(WB_We),     64'(last.we));
    chk("wb_onehot", 64'(WB_OneHot), last.we ? (64'd1 << last.dest) : 64'd0);
    chk("busy",      64'(Busy),      b);
    chk("rs_hit",    64'(Rs_Hit),    64'(b[Rs_Addr]));
    chk("rt_hit",    64'(Rt_Hit),    64'(b[Rt_Addr]));
  endtask

  task automatic drive(input int unsigned d, input bit w, input bit st, input bit fl,
                       input int unsigned rs, input int unsigned rt);
    Dest_In     = AW'(d);
    RegWrite_In = w;
    Stall       = st;
    Flush       = fl;
    Rs_Addr     = AW'(rs);
    Rt_Addr     = AW'(rt);
  endtask

  task automatic tick();
    #1 check_all();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_clear();
    @(negedge Clk);
    @(negedge Clk);
    #1;
    chk("rst_wb_we",     64'(WB_We),     64'd0);
    chk("rst_wb_dest",   64'(WB_Dest),   64'd0);
    chk("rst_wb_onehot", 64'(WB_OneHot), 64'd0);
    chk("rst_busy",      64'(Busy),      64'd0);
    Rst_n = 1'b1;

    // Single write to r9: visible at write-back three edges after entry.
    drive(9, 1, 0, 0, 9, 0); tick();
    drive(0, 0, 0, 0, 9, 0);
    #1 chk("r9_busy_s0", 64'(Busy[9]), 64'd1); tick();
    chk("r9_busy_s1", 64'(Busy[9]), 64'd1); tick();
    chk("r9_busy_s2", 64'(Busy[9]), 64'd1);
    chk("r9_wb_onehot", 64'(WB_OneHot), 64'h200);
    chk("r9_wb_dest",   64'(WB_Dest),   64'd9);
    chk("r9_wb_we",     64'(WB_We),     64'd1); tick();
    chk("r9_busy_done", 64'(Busy[9]), 64'd0);
    chk("r9_wb_off",    64'(WB_We),   64'd0);

    // Two-cycle stall with r7 in stage 1 delays write-back by two edges.
    drive(7, 1, 0, 0, 7, 0); tick();
    drive(0, 0, 0, 0, 7, 0); tick();
    drive(0, 0, 1, 0, 7, 0);
    #1 chk("stall_rs_hit", 64'(Rs_Hit), 64'd1); tick();
    chk("stall_busy7", 64'(Busy[7]), 64'd1);
    chk("stall_no_wb", 64'(WB_We),   64'd0); tick();
    chk("stall_busy7b", 64'(Busy[7]), 64'd1);
    drive(0, 0, 0, 0, 7, 0); tick();
    chk("stall_wb_dest", 64'(WB_Dest), 64'd7);
    chk("stall_wb_we",   64'(WB_We),   64'd1);
    tick();

    // Flush on entry of r12 discards it entirely.
    drive(12, 1, 0, 1, 12, 12); tick();
    drive(0, 0, 0, 0, 12, 12);
    #1 chk("flush_busy12", 64'(Busy[12]), 64'd0);
    tick(); tick(); tick();

    // Flush during stall bubbles stage 0 only.
    drive(4, 1, 0, 0, 4, 6); tick();
    drive(6, 1, 0, 0, 4, 6); tick();
    drive(0, 0, 1, 1, 4, 6); tick();
    drive(0, 0, 0, 0, 4, 6);
    #1 chk("sflush_busy6", 64'(Busy[6]), 64'd0);
    chk("sflush_busy4", 64'(Busy[4]), 64'd1);
    tick(); tick(); tick();

    // Back-to-back 5, 5, 3.
    drive(5, 1, 0, 0, 5, 3); tick();
    tick();
    drive(3, 1, 0, 0, 5, 3); tick();
    drive(0, 0, 0, 0, 5, 3);
    #1 chk("b2b_oh0", 64'(WB_OneHot), 64'h20); tick();
    chk("b2b_oh1",    64'(WB_OneHot), 64'h20);
    chk("b2b_busy5a", 64'(Busy[5]),   64'd1); tick();
    chk("b2b_oh2",    64'(WB_OneHot), 64'h08);
    chk("b2b_busy5b", 64'(Busy[5]),   64'd0); tick();

    // Writes to r0.
    drive(0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick(); tick();
`ifdef DEST_PIPE_R0_SUPPRESS_EN
    chk("r0_onehot", 64'(WB_OneHot), 64'h0);
    chk("r0_we",     64'(WB_We),     64'd0);
`else
    chk("r0_onehot", 64'(WB_OneHot), 64'h1);
    chk("r0_we",     64'(WB_We),     64'd1);
`endif
    tick();

    // Mid-stream async reset with three valid entries in flight.
    drive(1, 1, 0, 0, 1, 2); tick();
    drive(2, 1, 0, 0, 1, 2); tick();
    drive(3, 1, 0, 0, 1, 2); tick();
    drive(0, 0, 0, 0, 1, 2);
    Rst_n = 1'b0;
    model_clear();
    #1;
    chk("mrst_wb_we",  64'(WB_We),     64'd0);
    chk("mrst_wb_dst", 64'(WB_Dest),   64'd0);
    chk("mrst_oh",     64'(WB_OneHot), 64'd0);
    chk("mrst_busy",   64'(Busy),      64'd0);
    chk("mrst_rs",     64'(Rs_Hit),    64'd0);
    chk("mrst_rt",     64'(Rt_Hit),    64'd0);
    tick();
    Rst_n = 1'b1;
    tick(); tick(); tick();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(NR-1), 1'($urandom_range(3) != 0),
            1'($urandom_range(4) == 0), 1'($urandom_range(9) == 0),
            $urandom_range(NR-1), $urandom_range(NR-1));
      if ($urandom_range(99) == 0) begin
        Rst_n = 1'b0;
        model_clear();
      end else begin
        Rst_n = 1'b1;
      end
      tick();
    end
    Rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
